// File: rtl/eeprom_port_arbiter_if.sv
// Requester and EEPROM-side signals of the EEPROM port arbiter.
// The slave modport is the arbiter side, and the master modport is the requester/EEPROM side.
interface eeprom_port_arbiter_if;
    // Each requester holds req, we, addr and wdata stable until it sees its
    // one-cycle gnt. After gnt, req is free. A req that is still high after
    // done counts as a new request.
    logic        cmd_req;
    logic        cmd_we;
    logic [17:0] cmd_addr;
    logic [15:0] cmd_wdata;
    logic        cmd_gnt;
    logic        cmd_done;
    logic        cmd_err;
    logic        scan_req;
    logic        scan_we;
    logic [17:0] scan_addr;
    logic [15:0] scan_wdata;
    logic        scan_gnt;
    logic        scan_done;
    logic        scan_err;
    logic [15:0] rdata;
    logic        busy;
    logic [15:0] readBus_EEPROM;
    logic [17:0] readAddr_EEPROM;
    logic        we_EEPROM;
    logic [15:0] writeAddr_EEPROM;
    logic [15:0] writeBus_EEPROM;

    modport slave (
        input  cmd_req, cmd_we, cmd_addr, cmd_wdata,
        input  scan_req, scan_we, scan_addr, scan_wdata,
        input  readBus_EEPROM,
        output cmd_gnt, cmd_done, cmd_err,
        output scan_gnt, scan_done, scan_err,
        output rdata, busy,
        output readAddr_EEPROM, we_EEPROM, writeAddr_EEPROM, writeBus_EEPROM
    );

    modport master (
        output cmd_req, cmd_we, cmd_addr, cmd_wdata,
        output scan_req, scan_we, scan_addr, scan_wdata,
        output readBus_EEPROM,
        input  cmd_gnt, cmd_done, cmd_err,
        input  scan_gnt, scan_done, scan_err,
        input  rdata, busy,
        input  readAddr_EEPROM, we_EEPROM, writeAddr_EEPROM, writeBus_EEPROM
    );
endinterface

// File: rtl/eeprom_port_arbiter.sv
// Arbitrates one EEPROM port between the command path and the sensor scanner.
// Command has fixed priority, and a starvation counter forces a scan grant when it saturates.
module eeprom_port_arbiter #(
    parameter int READ_LAT     = 1,
    parameter int WRITE_CYCLES = 4,
    parameter int STARVE_MAX   = 8
) (
    input  logic                  clock,
    input  logic                  rst_n,
    eeprom_port_arbiter_if.slave  bus,
    output logic [1:0]            dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, FINISH = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  starve_q, starve_d;
    logic        owner_q, owner_d;
    logic        rej_q, rej_d;
    logic [17:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic        cmd_gnt_q, cmd_gnt_d, cmd_done_q, cmd_done_d, cmd_err_q, cmd_err_d;
    logic        scan_gnt_q, scan_gnt_d, scan_done_q, scan_done_d, scan_err_q, scan_err_d;
    logic [17:0] rd_addr_q, rd_addr_d;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;

    logic        sel_scan;
    logic        sel_we;
    logic [17:0] sel_addr;
    logic [15:0] sel_wdata;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        owner_d     = owner_q;
        rej_d       = rej_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cmd_gnt_d   = 1'b0;
        cmd_done_d  = 1'b0;
        cmd_err_d   = 1'b0;
        scan_gnt_d  = 1'b0;
        scan_done_d = 1'b0;
        scan_err_d  = 1'b0;
        rd_addr_d   = '0;
        wr_en_d     = 1'b0;
        wr_addr_d   = '0;
        wr_data_d   = '0;
        sel_scan    = bus.scan_req && (!bus.cmd_req || starve_q == 4'(STARVE_MAX));
        sel_we      = sel_scan ? bus.scan_we    : bus.cmd_we;
        sel_addr    = sel_scan ? bus.scan_addr  : bus.cmd_addr;
        sel_wdata   = sel_scan ? bus.scan_wdata : bus.cmd_wdata;

        unique case (state_q)
            IDLE: begin
                if (!bus.scan_req) starve_d = '0;
                // The cycle that shows done is not a decision cycle, so a req
                // still held at done is granted one cycle later.
                if ((bus.cmd_req || bus.scan_req) && !(cmd_done_q || scan_done_q)) begin
                    owner_d = sel_scan;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    if (sel_scan) begin
                        scan_gnt_d = 1'b1;
                        starve_d   = '0;
                    end else begin
                        cmd_gnt_d = 1'b1;
                        if (bus.scan_req && starve_q < 4'(STARVE_MAX)) starve_d = starve_q + 4'd1;
                    end
                    if (!sel_we) begin
                        state_d   = READ;
                        cnt_d     = 4'(READ_LAT - 1);
                        rd_addr_d = sel_addr;
                        rej_d     = 1'b0;
                    end else if (sel_addr[17:16] == 2'b00) begin
                        state_d   = WRITE;
                        cnt_d     = 4'(WRITE_CYCLES - 1);
                        wr_en_d   = 1'b1;
                        wr_addr_d = sel_addr[15:0];
                        wr_data_d = sel_wdata;
                        rej_d     = 1'b0;
                    end else begin
                        state_d = FINISH;
                        rej_d   = 1'b1;
                    end
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = bus.readBus_EEPROM;
                    state_d = FINISH;
                end else begin
                    cnt_d     = cnt_q - 4'd1;
                    rd_addr_d = addr_q;
                end
            end
            WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d = FINISH;
                end else begin
                    cnt_d     = cnt_q - 4'd1;
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q[15:0];
                    wr_data_d = wdata_q;
                end
            end
            FINISH: begin
                state_d     = IDLE;
                cmd_done_d  = !owner_q;
                cmd_err_d   = !owner_q && rej_q;
                scan_done_d = owner_q;
                scan_err_d  = owner_q && rej_q;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            starve_q    <= '0;
            owner_q     <= 1'b0;
            rej_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            cmd_gnt_q   <= 1'b0;
            cmd_done_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
            scan_gnt_q  <= 1'b0;
            scan_done_q <= 1'b0;
            scan_err_q  <= 1'b0;
            rd_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            rej_q       <= rej_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            cmd_gnt_q   <= cmd_gnt_d;
            cmd_done_q  <= cmd_done_d;
            cmd_err_q   <= cmd_err_d;
            scan_gnt_q  <= scan_gnt_d;
            scan_done_q <= scan_done_d;
            scan_err_q  <= scan_err_d;
            rd_addr_q   <= rd_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign bus.cmd_gnt          = cmd_gnt_q;
    assign bus.cmd_done         = cmd_done_q;
    assign bus.cmd_err          = cmd_err_q;
    assign bus.scan_gnt         = scan_gnt_q;
    assign bus.scan_done        = scan_done_q;
    assign bus.scan_err         = scan_err_q;
    assign bus.rdata            = rdata_q;
    assign bus.busy             = busy_q;
    assign bus.readAddr_EEPROM  = rd_addr_q;
    assign bus.we_EEPROM        = wr_en_q;
    assign bus.writeAddr_EEPROM = wr_addr_q;
    assign bus.writeBus_EEPROM  = wr_data_q;
    assign dbg_state            = state_q;
endmodule

// File: doc/eeprom_port_arbiter.md
Name: eeprom_port_arbiter

Overview:
- Shares the single EEPROM port between two requesters: the command path (decode_OP writes and reads) and the sensor-scan controller (sensor-info and lookup-table reads).
- Serialises accesses and enforces a fixed read latency and a fixed write hold time.
- Uses fixed command priority with an anti-starvation override, so background scanning is never blocked indefinitely by command traffic.

Parameters:
- READ_LAT, 1: cycles from readAddr_EEPROM driven to readBus_EEPROM valid (1..7).
- WRITE_CYCLES, 4: cycles we_EEPROM is held high per write (1..15).
- STARVE_MAX, 8: consecutive command wins against a pending scan request before scan is forced (1..15).

Ports:
- clock, input, 1: system clock.
- rst_n, input, 1: reset.
- cmd_req, input, 1: command requester access request.
- cmd_we, input, 1: 1 = write, 0 = read.
- cmd_addr, input, 18: access address.
- cmd_wdata, input, 16: write data.
- cmd_gnt, output, 1: 1-cycle pulse, request accepted.
- cmd_done, output, 1: 1-cycle pulse, access complete.
- cmd_err, output, 1: 1-cycle pulse with cmd_done, access rejected.
- scan_req, scan_we, scan_addr[17:0], scan_wdata[15:0], input: sensor-scan requester, same meaning as cmd_*.
- scan_gnt, scan_done, scan_err, output, 1 each: same meaning as cmd_*.
- rdata, output, 16: read data, valid in the cycle the owner's done is high, held until the next read completes.
- busy, output, 1: high whenever state != IDLE.
- readBus_EEPROM, input, 16: EEPROM read data.
- readAddr_EEPROM, output, 18: EEPROM read address.
- we_EEPROM, output, 1: EEPROM write enable.
- writeAddr_EEPROM, output, 16: EEPROM write address.
- writeBus_EEPROM, output, 16: EEPROM write data.

Behaviour:
- Reset and clocking: reset rst_n, asynchronous, active-low; clock clock. All state and outputs are registered.
- Reset values: every output 0, state IDLE, starve counter 0, latched owner/address/data 0.
- States: IDLE, READ, WRITE, FINISH.
- IDLE:
  - If either req is high, pick a winner and latch owner, we, addr and wdata.
  - Pulse the winner's gnt on the next cycle.
  - Move to READ (we=0), WRITE (we=1, addr[17:16]==0) or FINISH with error (we=1, addr[17:16]!=0).
- Handshake:
  - Requester holds req and its fields stable until it sees gnt.
  - After gnt it may deassert or change req freely; fields are ignored until the next grant.
  - A req still high in the cycle after done is treated as a new request.
- Priority:
  - cmd wins ties unless starve_cnt == STARVE_MAX; then scan wins.
  - starve_cnt increments when scan_req is high in IDLE and cmd is granted.
  - starve_cnt clears on a scan grant, or when scan_req is low in IDLE.
  - starve_cnt saturates at STARVE_MAX.
- READ:
  - readAddr_EEPROM = latched addr, held for READ_LAT cycles (down-counter).
  - At expiry, rdata <= readBus_EEPROM, then go to FINISH.
- WRITE:
  - we_EEPROM=1, writeAddr_EEPROM = addr[15:0], writeBus_EEPROM = wdata, held for exactly WRITE_CYCLES cycles; then FINISH.
  - Rejected writes never assert we_EEPROM.
- FINISH:
  - Pulse the owner's done for one cycle (plus err if rejected), drive all EEPROM outputs to 0, return to IDLE.
  - The next grant decision is made in IDLE, so back-to-back accesses have ≥2 idle/overhead cycles between done and the next access start.
- EEPROM outputs are 0 whenever the arbiter is not in READ or WRITE. readAddr_EEPROM and we_EEPROM are never active together.
- Only the owner ever sees gnt/done/err; the other requester's outputs stay 0.
- Reset mid-access: the access is aborted. No done is issued, we_EEPROM drops asynchronously, and requesters must re-request.
- rdata is unchanged by writes and rejected accesses.

Test Plan:
- Reset, then scan read addr 18'h1_0000, READ_LAT=1, readBus=16'hA5A5 -> scan_gnt 1 cycle after req; readAddr_EEPROM=18'h1_0000 for 1 cycle; scan_done with rdata=16'hA5A5; cmd_* outputs stay 0.
- cmd write addr 16'h0010, data 16'h1234, WRITE_CYCLES=4 -> we_EEPROM high exactly 4 cycles with writeAddr=16'h0010 and writeBus=16'h1234; then cmd_done; rdata unchanged.
- cmd write addr 18'h2_0003 -> cmd_gnt, then cmd_done and cmd_err in the same cycle; we_EEPROM never high.
- cmd_req and scan_req held high continuously, STARVE_MAX=8 -> 8 cmd grants, 9th grant to scan, counter clears, cmd resumes; pattern repeats.
- Both requests in the same IDLE cycle with starve_cnt=0 -> cmd granted first; scan granted on the next IDLE; scan fields stay stable until scan_gnt.
- rst_n asserted mid-WRITE (cycle 2 of 4) -> we_EEPROM=0 immediately; no cmd_done; busy=0; after release, the next request is granted normally.
